dataram_portb_arbiter: RTL and testbench

Two-requester arbiter and sequencer for port b of the CPU data RAM: the 16 KiB, 4096-word synchronous dual-port RAM with byte write enables. Port a belongs to the CPU. This block shares port b between the debug module (requester 0) and the program/data loader (requester 1). It arbitrates round-robin, drives the RAM with registered controls, and returns a captured read word and an out-of-range flag to the winner.

---
 rtl/dataram_portb_arbiter.sv | 97 +++++++++
 tb/tb_dataram_portb_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dataram_portb_arbiter.sv
// Port-b sequencer for the CPU data RAM: round-robin (or fixed-priority) sharing
// between the debug module (requester 0) and the loader (requester 1).
`timescale 1ns/1ps
module dataram_portb_arbiter #(
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0,
   input  logic        req1,
   input  logic [3:0]  we0,
   input  logic [3:0]  we1,
   input  logic [29:0] addr0,
   input  logic [29:0] addr1,
   input  logic [31:0] wdata0,
   input  logic [31:0] wdata1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        rvalid0,
   output logic        rvalid1,
   output logic [31:0] rdata,
   output logic        rerr,
   output logic        busy,
   output logic [3:0]  web,
   output logic [29:0] addrb,
   output logic [31:0] dinb,
   input  logic [31:0] doutb
);

   typedef enum logic [1:0] {IDLE, ISSUE, DATA, RESP} state_t;

   state_t state, state_nxt;
   logic   owner;
   logic   last;
   logic   arb;
   logic   win;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      arb       = 1'b0;
      win       = 1'b0;
      case (state)
         IDLE, RESP: begin
            state_nxt = IDLE;
            if (req0 || req1) begin
               arb       = 1'b1;
               state_nxt = ISSUE;
               // On a tie the requester not granted last time wins.
               if (req0 && req1) win = FIXED_PRIO ? 1'b0 : ~last;
               else              win = req1;
            end
         end
         ISSUE:   state_nxt = DATA;
         DATA:    state_nxt = RESP;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner <= 1'b0;
         last  <= 1'b1;
         web   <= '0;
         addrb <= '0;
         dinb  <= '0;
         rdata <= '0;
         rerr  <= 1'b0;
      end else begin
         if (arb) begin
            owner <= win;
            last  <= win;
            web   <= win ? we1    : we0;
            addrb <= win ? addr1  : addr0;
            dinb  <= win ? wdata1 : wdata0;
         end else if (state == ISSUE) begin
            web <= '0;
         end
         if (state == DATA) begin
            rdata <= doutb;
            rerr  <= |addrb[29:12];
         end
      end
   end

   // Handshake pulses decode straight from the registered state and owner.
   assign gnt0    = (state == ISSUE) && !owner;
   assign gnt1    = (state == ISSUE) &&  owner;
   assign rvalid0 = (state == RESP)  && !owner;
   assign rvalid1 = (state == RESP)  &&  owner;
   assign busy    = (state != IDLE);

endmodule

// File: tb/tb_dataram_portb_arbiter.sv
// Bench for dataram_portb_arbiter: RAM model, vector table, scoreboard of responses.
`timescale 1ns/1ps
module tb_dataram_portb_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req0 = 1'b0, req1 = 1'b0;
   logic [3:0]  we0 = '0, we1 = '0;
   logic [29:0] addr0 = '0, addr1 = '0;
   logic [31:0] wdata0 = '0, wdata1 = '0;
   logic        gnt0, gnt1, rvalid0, rvalid1, rerr, busy;
   logic [31:0] rdata, dinb;
   logic [3:0]  web;
   logic [29:0] addrb;
   logic [31:0] doutb = '0;

   logic        fp_gnt0, fp_gnt1, fp_rvalid0, fp_rvalid1, fp_rerr, fp_busy;
   logic [31:0] fp_rdata, fp_dinb;
   logic [3:0]  fp_web;
   logic [29:0] fp_addrb;
   logic [31:0] fp_doutb;
   assign fp_doutb = '0;

   logic [31:0] mem [0:4095];

   int total = 0;
   int bad   = 0;

   typedef struct {
      int          id;
      logic [31:0] data;
      logic        err;
   } exp_t;
   exp_t sbq[$];

   typedef struct {
      int          id;
      logic [3:0]  we;
      logic [29:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_rerr;
   } vec_t;
   vec_t vecs[10];

   dataram_portb_arbiter #(.FIXED_PRIO(1'b0)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata(rdata), .rerr(rerr), .busy(busy),
      .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb)
   );

   dataram_portb_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(fp_gnt0), .gnt1(fp_gnt1), .rvalid0(fp_rvalid0), .rvalid1(fp_rvalid1),
      .rdata(fp_rdata), .rerr(fp_rerr), .busy(fp_busy),
      .web(fp_web), .addrb(fp_addrb), .dinb(fp_dinb), .doutb(fp_doutb)
   );

   always #5 clk = ~clk;

   // Read-first RAM; words outside the 4096-word range read 0 and ignore writes.
   always @(posedge clk) begin
      if (addrb[29:12] == '0) begin
         doutb <= mem[addrb[11:0]];
         for (int k = 0; k < 4; k++)
            if (web[k]) mem[addrb[11:0]][8*k +: 8] <= dinb[8*k +: 8];
      end else begin
         doutb <= '0;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input int id, input logic r, input logic [3:0] w,
                        input logic [29:0] a, input logic [31:0] d);
      if (id == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
      else         begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
   endtask

   task automatic expect_resp(input int id, input logic [31:0] d, input logic e);
      exp_t x;
      x.id = id; x.data = d; x.err = e;
      sbq.push_back(x);
   endtask

   exp_t got;
   always @(negedge clk) begin
      if (rst_n) begin
         if (rvalid0 || rvalid1) begin
            if (sbq.size() == 0) begin
               check("unexpected_rvalid", 1, 0);
            end else begin
               got = sbq.pop_front();
               check("rvalid_id", {63'd0, rvalid1}, got.id);
               check("rdata", rdata, got.data);
               check("rerr", rerr, got.err);
            end
         end
         check("gnt_excl", gnt0 & gnt1, 0);
         check("rvalid_excl", rvalid0 & rvalid1, 0);
         check("gnt_rvalid_overlap", (gnt0 & rvalid0) | (gnt1 & rvalid1), 0);
      end
   end

   task automatic run_txn(input vec_t v);
      expect_resp(v.id, v.exp_rdata, v.exp_rerr);
      @(negedge clk);
      drive(v.id, 1'b1, v.we, v.addr, v.wdata);
      @(posedge clk); #1;
      check("gnt", v.id ? gnt1 : gnt0, 1);
      check("gnt_other", v.id ? gnt0 : gnt1, 0);
      check("web_issue", web, v.we);
      check("addrb_issue", addrb, v.addr);
      check("dinb_issue", dinb, v.wdata);
      drive(v.id, 1'b0, '0, '0, '0);
      @(posedge clk); #1;
      check("web_data", web, 0);
      check("busy_data", busy, 1);
      @(posedge clk); #1;
      check("rvalid_latency", v.id ? rvalid1 : rvalid0, 1);
      @(posedge clk); #1;
      check("idle_after", busy, 0);
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = '0;
      mem[0]    = 32'hA5A5A5A5;
      mem[5]    = 32'hDEADBEEF;
      mem[9]    = 32'h99999999;
      mem[4095] = 32'h11223344;

      vecs[0] = '{0, 4'h0, 30'd5,     32'h0,        32'hDEADBEEF, 1'b0};
      vecs[1] = '{1, 4'h4, 30'd5,     32'h00AA0000, 32'hDEADBEEF, 1'b0};
      vecs[2] = '{0, 4'h0, 30'd5,     32'h0,        32'hDEAABEEF, 1'b0};
      vecs[3] = '{1, 4'hF, 30'd7,     32'h12345678, 32'h00000000, 1'b0};
      vecs[4] = '{0, 4'h0, 30'd7,     32'h0,        32'h12345678, 1'b0};
      vecs[5] = '{0, 4'hF, 30'h1000,  32'hFFFFFFFF, 32'h00000000, 1'b1};
      vecs[6] = '{1, 4'h0, 30'h1000,  32'h0,        32'h00000000, 1'b1};
      vecs[7] = '{1, 4'h0, 30'd0,     32'h0,        32'hA5A5A5A5, 1'b0};
      vecs[8] = '{0, 4'h1, 30'hFFF,   32'h000000CC, 32'h11223344, 1'b0};
      vecs[9] = '{1, 4'h0, 30'hFFF,   32'h0,        32'h112233CC, 1'b0};

      #1;
      check("reset_outputs", |{gnt0, gnt1, rvalid0, rvalid1, rerr, busy, web, addrb, dinb, rdata}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) run_txn(vecs[i]);

      // Both requesters held high: grants alternate every three cycles.
      expect_resp(0, 32'hDEAABEEF, 1'b0);
      expect_resp(1, 32'h12345678, 1'b0);
      expect_resp(0, 32'hDEAABEEF, 1'b0);
      expect_resp(1, 32'h12345678, 1'b0);
      @(negedge clk);
      drive(0, 1'b1, 4'h0, 30'd5, '0);
      drive(1, 1'b1, 4'h0, 30'd7, '0);
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); #1;
         check("rr_gnt0", gnt0, (k == 1 || k == 7));
         check("rr_gnt1", gnt1, (k == 4 || k == 10));
         check("fp_gnt0", fp_gnt0, (k == 1 || k == 4 || k == 7 || k == 10));
         check("fp_gnt1", fp_gnt1 | fp_rvalid1, 0);
         check("rr_busy", busy, 1);
         if (k == 10) begin
            drive(0, 1'b0, '0, '0, '0);
            drive(1, 1'b0, '0, '0, '0);
         end
      end
      @(posedge clk); #1;
      check("rr_idle", busy, 0);

      // Requester 1 enters during requester 0's RESP cycle.
      expect_resp(0, 32'h12345678, 1'b0);
      expect_resp(1, 32'hDEAABEEF, 1'b0);
      @(negedge clk);
      drive(0, 1'b1, 4'h0, 30'd7, '0);
      @(posedge clk); #1;
      check("b2b_gnt0", gnt0, 1);
      drive(0, 1'b0, '0, '0, '0);
      @(posedge clk); #1;
      check("b2b_busy2", busy, 1);
      @(posedge clk); #1;
      check("b2b_rvalid0", rvalid0, 1);
      check("b2b_busy3", busy, 1);
      drive(1, 1'b1, 4'h0, 30'd5, '0);
      @(posedge clk); #1;
      check("b2b_gnt1", gnt1, 1);
      check("b2b_busy4", busy, 1);
      drive(1, 1'b0, '0, '0, '0);
      @(posedge clk); #1;
      check("b2b_busy5", busy, 1);
      @(posedge clk); #1;
      check("b2b_rvalid1", rvalid1, 1);
      check("b2b_busy6", busy, 1);
      @(posedge clk); #1;
      check("b2b_idle", busy, 0);

      // Reset asserted in a write's ISSUE cycle.
      @(negedge clk);
      drive(0, 1'b1, 4'hF, 30'd9, 32'hCAFEF00D);
      @(posedge clk); #1;
      check("rst_gnt0", gnt0, 1);
      check("rst_web_before", web, 4'hF);
      rst_n = 1'b0;
      #1;
      check("rst_web_async", web, 0);
      check("rst_busy_async", busy, 0);
      drive(0, 1'b0, '0, '0, '0);
      repeat (3) @(posedge clk);
      #1;
      check("rst_mem_kept", mem[9], 32'h99999999);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_release_zero", |{gnt0, gnt1, rvalid0, rvalid1, rerr, busy, web, addrb, dinb, rdata}, 0);
      check("rst_release_fp_zero", |{fp_gnt0, fp_gnt1, fp_rvalid0, fp_rvalid1, fp_rerr, fp_busy,
                                     fp_web, fp_addrb, fp_dinb, fp_rdata}, 0);
      expect_resp(0, 32'h99999999, 1'b0);
      @(negedge clk);
      drive(0, 1'b1, 4'h0, 30'd9, '0);
      drive(1, 1'b1, 4'h0, 30'd5, '0);
      @(posedge clk); #1;
      check("tie_after_reset_gnt0", gnt0, 1);
      check("tie_after_reset_gnt1", gnt1, 0);
      drive(0, 1'b0, '0, '0, '0);
      drive(1, 1'b0, '0, '0, '0);
      repeat (2) @(posedge clk);
      #1;
      check("tie_after_reset_rvalid0", rvalid0, 1);

      for (int n = 0; n < 20 && sbq.size() != 0; n++) @(posedge clk);
      @(posedge clk); #1;
      check("scoreboard_drained", sbq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
